addsub_arbiter: RTL and testbench
=================================

Name: addsub_arbiter

Overview:
- Shares one 16-bit adder-subtractor datapath among NUM_REQ requesters.
- Arbitration is round-robin. Each accepted operation is sequenced through operand capture, compute and response hold.
- The arbiter tags each result with the requester index and returns it with overflow and carry flags over a valid/ready response channel.
- It sits between the requesting control units and the arithmetic datapath, and is the only driver of the datapath's operand and SUB inputs.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 16, operand/result width; the datapath is built for 16, other values are unsupported.
- ID_W, 2, width of the requester index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a
- req_sub  in  NUM_REQ  per-requester mode: 1 = A-B, 0 = A+B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_sum  out  WIDTH  A+B or A-B, modulo 2^WIDTH
- rsp_ovf  out  1  signed (two's-complement) overflow
- rsp_cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset: takes effect on a clk edge with rst=1 and overrides every other input.
  - FSM goes to IDLE; rr_ptr = 0.
  - rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_cout and busy = 0.
  - req_ready is all 0 while rst=1.
  - An operation in CALC or RESP at reset time is discarded; no response is issued.
- FSM states: IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[i]=1 combinationally for the granted i only. Acceptance = req_valid[i] & req_ready[i].
  - On acceptance: latch a_q=req_a[i], b_q=req_b[i], sub_q=req_sub[i], id_q=i; set rr_ptr=(i+1) mod NUM_REQ; go to CALC.
  - With no valid request: stay in IDLE; rr_ptr unchanged.
- CALC:
  - Drive the datapath with a_q, b_q XOR {WIDTH{sub_q}}, carry-in = sub_q.
  - At the clock edge, register the sum, ovf = carry_into_MSB XOR carry_out, and cout into the rsp_* registers. Set rsp_valid=1 and rsp_id=id_q; go to RESP.
  - req_ready is all 0.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0; back-pressure is unbounded.
  - On rsp_ready=1: rsp_valid goes to 0 at the next edge and the FSM returns to IDLE. rsp_sum, rsp_ovf, rsp_cout and rsp_id keep their last values.
  - req_ready is all 0.
- Timing:
  - Latency from acceptance edge to rsp_valid=1 is 2 cycles.
  - Minimum spacing between acceptances is 3 cycles; the next acceptance occurs no earlier than the cycle after the response handshake.
- A requester that drops req_valid before acceptance loses its place; no request is queued internally.
- Operand inputs are sampled only at the acceptance edge; later changes do not affect the result in flight.
- Fairness: with all requesters continuously valid, grant order is 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 grants.

Test Plan:
- Add with overflow: reset, then req 0 valid with a=0x7FFF, b=0x0001, sub=0 -> req_ready[0]=1 in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_sum=0x8000, rsp_ovf=1, rsp_cout=0.
- Subtract with borrow: req 2, a=0x0005, b=0x0007, sub=1 -> rsp_sum=0xFFFE, rsp_ovf=0, rsp_cout=0. Then a=0x8000, b=0x0001, sub=1 -> rsp_sum=0x7FFF, rsp_ovf=1, rsp_cout=1.
- Round-robin: all 4 req_valid held high with distinct operands, rsp_ready=1 -> grants in order 0,1,2,3,0 with rsp_id matching. Each acceptance is exactly 3 cycles apart; req_ready is one-hot or zero every cycle.
- Back-pressure: rsp_ready=0 for 10 cycles in RESP -> rsp_* constant, busy=1, req_ready all 0. Raising rsp_ready -> rsp_valid=0 next cycle; the next grant is the requester after the last one served.
- Reset mid-operation: assert rst in CALC, and separately in RESP -> next cycle: FSM in IDLE, rsp_valid=0, busy=0, rr_ptr=0. A subsequent request from req 3 only (a=0xFFFF, b=0x0001, sub=0) -> rsp_sum=0x0000, rsp_cout=1, rsp_ovf=0.
- Operand stability: change req_a/req_b of the accepted requester in the cycle after acceptance -> result reflects the values sampled at the acceptance edge.

Source files
------------

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter sharing one 16-bit add/sub datapath.
// Grants one requester at a time and returns a tagged result with flags.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/ready     per-requester handshake, ready is one-hot or zero
//   req_a, req_b        packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sub             per-requester mode, 1 = A-B, 0 = A+B
//   rsp_valid/ready     result handshake
//   rsp_id              index of the requester owning the result
//   rsp_sum             A+B or A-B modulo 2^WIDTH
//   rsp_ovf, rsp_cout   signed overflow, carry out (1 = no borrow on sub)
//   busy                high while an operation is in flight
module addsub_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_ovf,
    output logic                     rsp_cout,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sub_q;

    logic              gnt_found;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   nxt_ptr;
    logic [ID_W:0]     cand;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic              sel_sub;

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  low;
    logic              c_msb;
    logic [1:0]        top;

    // Walk offsets from the highest down so the smallest offset from
    // rr_ptr wins; that is the first valid requester at or after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        if (gnt_id == ID_W'(NUM_REQ - 1)) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = gnt_id + ID_W'(1);
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_a   = req_a[i*WIDTH +: WIDTH];
                sel_b   = req_b[i*WIDTH +: WIDTH];
                sel_sub = req_sub[i];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && gnt_found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (gnt_id == ID_W'(i));
            end
        end
    end

    // Split the adder at the MSB so the carry into the sign bit is
    // visible; overflow is that carry XOR the final carry out.
    always_comb begin
        b_eff = b_q ^ {WIDTH{sub_q}};
        low   = {1'b0, a_q[WIDTH-2:0]}
              + {1'b0, b_eff[WIDTH-2:0]}
              + {{(WIDTH-1){1'b0}}, sub_q};
        c_msb = low[WIDTH-1];
        top   = {1'b0, a_q[WIDTH-1]}
              + {1'b0, b_eff[WIDTH-1]}
              + {1'b0, c_msb};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            rsp_cout  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        a_q    <= sel_a;
                        b_q    <= sel_b;
                        sub_q  <= sel_sub;
                        id_q   <= gnt_id;
                        rr_ptr <= nxt_ptr;
                        busy   <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= {top[0], low[WIDTH-2:0]};
                    rsp_ovf   <= c_msb ^ top[1];
                    rsp_cout  <= top[1];
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed plus random stimulus for addsub_arbiter.
// A behavioural reference is compared with the DUT on every cycle.
module tb_addsub_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_sub;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_ovf;
    logic           rsp_cout;
    logic           busy;

    always #5 clk = ~clk;

    addsub_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_ovf(rsp_ovf), .rsp_cout(rsp_cout), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Reference arithmetic straight from integer semantics.
    function automatic void ref_calc(input logic [15:0] a, input logic [15:0] b,
                                     input logic sub, output logic [15:0] s,
                                     output logic ovf, output logic cout);
        int sa, sb, r, ua, ub, u;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        r = sub ? sa - sb : sa + sb;
        u = sub ? ua - ub : ua + ub;
        ovf = (r > 32767) || (r < -32768);
        s = u[15:0];
        cout = sub ? (ua >= ub) : (u > 65535);
    endfunction

    function automatic int pick(logic [N-1:0] v, logic [1:0] p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(p) + k) % N;
            if (v[2'(j)]) return j;
        end
        return -1;
    endfunction

    // Model: m_age counts edges since acceptance (0 = nothing in flight).
    int         m_age = 0;
    logic [1:0] m_ptr = '0;
    logic [1:0] m_id;
    logic [15:0] m_a, m_b;
    logic       m_sub;
    logic [1:0] e_id;
    logic [15:0] e_sum;
    logic       e_ovf, e_cout;
    bit         m_init = 1'b0;
    int         acc_id[$];
    int         acc_cyc[$];

    always @(negedge clk) begin
        int g;
        logic [N-1:0] exp_rdy;
        cyc++;
        g = pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (!rst && m_age == 0 && g >= 0) exp_rdy = 4'(1 << g);
        if (m_init) begin
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            check("busy", 32'(busy), 32'(m_age != 0));
            check("rsp_valid", 32'(rsp_valid), 32'(m_age == 2));
            check("rsp_id", 32'(rsp_id), 32'(e_id));
            check("rsp_sum", 32'(rsp_sum), 32'(e_sum));
            check("rsp_ovf", 32'(rsp_ovf), 32'(e_ovf));
            check("rsp_cout", 32'(rsp_cout), 32'(e_cout));
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (req_valid[2'(i)] && req_ready[2'(i)]) begin
                        acc_id.push_back(i);
                        acc_cyc.push_back(cyc);
                    end
                end
            end
        end
        if (rst) begin
            m_init = 1'b1;
            m_age  = 0;
            m_ptr  = '0;
            e_id   = '0;
            e_sum  = '0;
            e_ovf  = 1'b0;
            e_cout = 1'b0;
        end else if (m_init) begin
            case (m_age)
                0: if (g >= 0) begin
                    m_a   = req_a[g*W +: W];
                    m_b   = req_b[g*W +: W];
                    m_sub = req_sub[2'(g)];
                    m_id  = 2'(g);
                    m_ptr = 2'((g + 1) % N);
                    m_age = 1;
                end
                1: begin
                    ref_calc(m_a, m_b, m_sub, e_sum, e_ovf, e_cout);
                    e_id  = m_id;
                    m_age = 2;
                end
                default: if (rsp_ready) m_age = 0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(int i, logic [15:0] a, logic [15:0] b, logic s);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[2'(i)] = s;
    endtask

    task automatic wait_ready(int i, string tag, output int n);
        bit ok = 1'b0;
        n = 0;
        while (!ok && n < 12) begin
            @(negedge clk);
            n++;
            if (req_ready[2'(i)]) ok = 1'b1;
        end
        if (!ok) timeout({tag, "_ready"});
    endtask

    task automatic wait_rsp(string tag, output int n);
        bit ok = 1'b0;
        n = 0;
        while (!ok && n < 12) begin
            @(negedge clk);
            n++;
            if (rsp_valid) ok = 1'b1;
        end
        if (!ok) timeout({tag, "_rsp"});
    endtask

    task automatic do_op(int i, logic [15:0] a, logic [15:0] b, logic s,
                         logic [15:0] xs, logic xo, logic xc,
                         bit scramble, string tag);
        int n;
        step();
        req_valid = 4'(1 << i);
        set_op(i, a, b, s);
        rsp_ready = 1'b1;
        wait_ready(i, tag, n);
        check({tag, "_wait"}, 32'(n), 1);
        check({tag, "_rdy"}, 32'(req_ready), 32'(1 << i));
        step();
        req_valid = '0;
        if (scramble) set_op(i, ~a, b ^ 16'h5A5A, ~s);
        wait_rsp(tag, n);
        check({tag, "_lat"}, 32'(n), 2);
        check({tag, "_id"}, 32'(rsp_id), 32'(i));
        check({tag, "_sum"}, 32'(rsp_sum), 32'(xs));
        check({tag, "_ovf"}, 32'(rsp_ovf), 32'(xo));
        check({tag, "_cout"}, 32'(rsp_cout), 32'(xc));
        step();
        @(negedge clk);
        check({tag, "_done"}, 32'(rsp_valid), 0);
    endtask

    initial begin
        int n;
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sub = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        do_op(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b0, "add_ovf");
        do_op(2, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, "sub_borrow");
        do_op(2, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");

        // Back-pressure on the first grant, then free-running round-robin.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        acc_id.delete();
        acc_cyc.delete();
        for (int i = 0; i < N; i++) begin
            set_op(i, 16'(16'h1000 * (i + 1)), 16'(i + 3), 1'(i));
        end
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        wait_rsp("bp", n);
        repeat (10) begin
            @(negedge clk);
            check("bp_ready", 32'(req_ready), 0);
            check("bp_busy", 32'(busy), 1);
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 0);
            check("bp_sum", 32'(rsp_sum), 32'h1003);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release", 32'(rsp_valid), 0);
        repeat (14) @(negedge clk);
        step();
        req_valid = '0;
        check("rr_count", 32'(acc_id.size() >= 5), 1);
        if (acc_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("rr_id%0d", k), 32'(acc_id[k]), 32'(rr_exp[k]));
            end
            for (int k = 2; k < 5; k++) begin
                check($sformatf("rr_gap%0d", k),
                      32'(acc_cyc[k] - acc_cyc[k-1]), 3);
            end
        end

        // Reset while in CALC, then while in RESP.
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 16'h0101, 16'h0202, 1'b0);
        wait_ready(1, "rst_calc", n);
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_calc_valid", 32'(rsp_valid), 0);
        check("rst_calc_busy", 32'(busy), 0);
        step();
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rst_ptr", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        wait_rsp("rst_resp", n);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 32'(rsp_valid), 0);
        check("rst_resp_busy", 32'(busy), 0);
        check("rst_resp_sum", 32'(rsp_sum), 0);
        do_op(3, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, "wrap");

        do_op(0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1, "stable_add");
        do_op(1, 16'h0010, 16'h0020, 1'b1, 16'hFFF0, 1'b0, 1'b0, 1'b1, "stable_sub");

        repeat (3000) begin
            step();
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) begin
                set_op(i, 16'($urandom), 16'($urandom), 1'($urandom));
            end
            rsp_ready = ($urandom % 10) < 7;
            rst = ($urandom % 100) == 0;
        end
        step();
        rst = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
